uart_rx_adv: RTL and testbench

UART_RX_ADV -- requirements
Module: uart_rx_adv

---
 rtl/uart_rx_adv.sv | 267 ++++++++++++++++++++++++++
 tb/tb_uart_rx_adv.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_adv.sv
// Oversampling UART receiver with 2-of-3 mid-bit voting, 5..9 data bits, parity and
// one or two stop bits, a single-word holding register with overrun and idle timeout.
module uart_rx_adv #(
  parameter int MAX_BITS = 9,
  parameter int OVS      = 16,
  parameter int DIV_W    = 16,
  parameter int TO_W     = 8
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                rx_i,
  input  logic                cfg_en_i,
  input  logic [DIV_W-1:0]    cfg_div_i,
  input  logic [2:0]          cfg_bits_i,
  input  logic [2:0]          cfg_parity_i,
  input  logic                cfg_stop_i,
  input  logic [TO_W-1:0]     cfg_to_i,
  output logic [MAX_BITS-1:0] rx_data_o,
  output logic                rx_pe_o,
  output logic                rx_fe_o,
  output logic                rx_brk_o,
  output logic                rx_valid_o,
  input  logic                rx_ready_i,
  output logic                overrun_o,
  output logic                timeout_o,
  output logic                busy_o
);

  localparam int SW = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [SW-1:0] SMP_A    = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] SMP_B    = SW'(OVS / 2);
  localparam logic [SW-1:0] SMP_C    = SW'(OVS / 2 + 1);
  localparam logic [SW-1:0] SMP_LAST = SW'(OVS - 1);
  localparam logic [3:0]    NB_MAX   = 4'(MAX_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [1:0]          r_sync;
  logic                r_rx_prev;
  logic                w_rx;
  logic                w_start;
  logic                w_tick;
  logic [DIV_W-1:0]    r_div;
  logic [SW-1:0]       r_smp;
  logic                r_s0;
  logic                r_s1;
  logic                w_vote_en;
  logic                w_vote;

  logic [3:0]          w_bits_req;
  logic [3:0]          w_nbits;
  logic [3:0]          r_nbits;
  logic [3:0]          r_bit_idx;
  logic                r_par_en;
  logic [1:0]          r_par_mode;
  logic                r_stop2;
  logic [MAX_BITS-1:0] r_shift;
  logic                r_pe;
  logic                r_fe;
  logic                r_zero;
  logic                w_par_exp;
  logic                w_done;
  logic                w_hs;

  logic [SW-1:0]       r_to_sub;
  logic [TO_W-1:0]     r_to_cnt;
  logic                r_to_done;

  assign w_rx      = r_sync[1];
  assign w_start   = cfg_en_i && (r_state == IDLE) && r_rx_prev && !w_rx;
  assign w_tick    = cfg_en_i && (r_div >= cfg_div_i);
  assign w_vote_en = (r_state != IDLE) && w_tick && (r_smp == SMP_C);
  assign w_vote    = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
  assign w_hs      = rx_valid_o && rx_ready_i;
  assign busy_o    = (r_state != IDLE);

  assign w_bits_req = 4'd5 + {1'b0, cfg_bits_i};
  assign w_nbits    = (w_bits_req > NB_MAX) ? NB_MAX : w_bits_req;

  always_comb begin
    w_par_exp = 1'b0;
    case (r_par_mode)
      2'b00:   w_par_exp = ^r_shift;
      2'b01:   w_par_exp = ~^r_shift;
      2'b10:   w_par_exp = 1'b1;
      default: w_par_exp = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], rx_i};
      r_rx_prev <= w_rx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || !cfg_en_i || w_start) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Sample counter runs across bit boundaries; states advance at the mid-bit vote.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || w_start) begin
      r_smp <= '0;
      r_s0  <= 1'b1;
      r_s1  <= 1'b1;
    end else if ((r_state != IDLE) && w_tick) begin
      r_smp <= (r_smp == SMP_LAST) ? '0 : r_smp + SW'(1);
      if (r_smp == SMP_A) r_s0 <= w_rx;
      if (r_smp == SMP_B) r_s1 <= w_rx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    if (!cfg_en_i) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:   if (w_start) w_state_nxt = START;
        START:  if (w_vote_en) w_state_nxt = w_vote ? IDLE : DATA;
        DATA: begin
          if (w_vote_en && (r_bit_idx == r_nbits - 4'd1)) begin
            w_state_nxt = r_par_en ? PARITY : STOP1;
          end
        end
        PARITY: if (w_vote_en) w_state_nxt = STOP1;
        STOP1: begin
          if (w_vote_en) begin
            if (r_stop2) begin
              w_state_nxt = STOP2;
            end else begin
              w_state_nxt = IDLE;
              w_done      = 1'b1;
            end
          end
        end
        STOP2: begin
          if (w_vote_en) begin
            w_state_nxt = IDLE;
            w_done      = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_nbits    <= '0;
      r_bit_idx  <= '0;
      r_par_en   <= 1'b0;
      r_par_mode <= '0;
      r_stop2    <= 1'b0;
      r_shift    <= '0;
      r_pe       <= 1'b0;
      r_fe       <= 1'b0;
      r_zero     <= 1'b0;
    end else if (w_start) begin
      r_nbits    <= w_nbits;
      r_bit_idx  <= '0;
      r_par_en   <= cfg_parity_i[0];
      r_par_mode <= cfg_parity_i[2:1];
      r_stop2    <= cfg_stop_i;
      r_shift    <= '0;
      r_pe       <= 1'b0;
      r_fe       <= 1'b0;
      r_zero     <= 1'b1;
    end else if (w_vote_en) begin
      case (r_state)
        DATA: begin
          for (int unsigned i = 0; i < MAX_BITS; i++) begin
            if (r_bit_idx == 4'(i)) r_shift[i] <= w_vote;
          end
          r_bit_idx <= r_bit_idx + 4'd1;
          r_zero    <= r_zero & ~w_vote;
        end
        PARITY: begin
          r_pe   <= (w_vote != w_par_exp);
          r_zero <= r_zero & ~w_vote;
        end
        STOP1, STOP2: begin
          r_fe   <= r_fe | ~w_vote;
          r_zero <= r_zero & ~w_vote;
        end
        default: ;
      endcase
    end
  end

  // Final stop vote is folded in directly so the word lands together with the IDLE return.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rx_data_o  <= '0;
      rx_pe_o    <= 1'b0;
      rx_fe_o    <= 1'b0;
      rx_brk_o   <= 1'b0;
      rx_valid_o <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (w_done && (!rx_valid_o || rx_ready_i)) begin
        rx_data_o  <= r_shift;
        rx_pe_o    <= r_pe;
        rx_fe_o    <= r_fe | ~w_vote;
        rx_brk_o   <= r_zero & ~w_vote;
        rx_valid_o <= 1'b1;
      end else begin
        if (w_done) overrun_o <= 1'b1;
        if (w_hs) rx_valid_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || !cfg_en_i || w_start || w_hs) begin
      r_to_sub  <= '0;
      r_to_cnt  <= '0;
      r_to_done <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      if ((r_state == IDLE) && rx_valid_o && w_tick && !r_to_done) begin
        if (r_to_sub == SMP_LAST) begin
          r_to_sub <= '0;
          r_to_cnt <= r_to_cnt + TO_W'(1);
          if ((cfg_to_i != '0) && (r_to_cnt + TO_W'(1) == cfg_to_i)) begin
            timeout_o <= 1'b1;
            r_to_done <= 1'b1;
          end
        end else begin
          r_to_sub <= r_to_sub + SW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_adv.sv
// Randomized self-checking bench for uart_rx_adv: directed framing scenarios plus random
// frames compared against a frame-level reference model.
module tb_uart_rx_adv;

  localparam int MAX_BITS = 9;
  localparam int OVS      = 16;
  localparam int DIV_W    = 16;
  localparam int TO_W     = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                rx;
  logic                cfg_en;
  logic [DIV_W-1:0]    cfg_div;
  logic [2:0]          cfg_bits;
  logic [2:0]          cfg_parity;
  logic                cfg_stop;
  logic [TO_W-1:0]     cfg_to;
  logic [MAX_BITS-1:0] rx_data;
  logic                rx_pe, rx_fe, rx_brk, rx_valid, rx_ready;
  logic                overrun, timeout, busy;

  always #5 clk = ~clk;

  uart_rx_adv #(
    .MAX_BITS(MAX_BITS),
    .OVS     (OVS),
    .DIV_W   (DIV_W),
    .TO_W    (TO_W)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .rx_i        (rx),
    .cfg_en_i    (cfg_en),
    .cfg_div_i   (cfg_div),
    .cfg_bits_i  (cfg_bits),
    .cfg_parity_i(cfg_parity),
    .cfg_stop_i  (cfg_stop),
    .cfg_to_i    (cfg_to),
    .rx_data_o   (rx_data),
    .rx_pe_o     (rx_pe),
    .rx_fe_o     (rx_fe),
    .rx_brk_o    (rx_brk),
    .rx_valid_o  (rx_valid),
    .rx_ready_i  (rx_ready),
    .overrun_o   (overrun),
    .timeout_o   (timeout),
    .busy_o      (busy)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Event monitor: pulse cycle counts and timestamps, sampled on the falling edge.
  int unsigned cyc       = 0;
  int unsigned ovr_hi    = 0;
  int unsigned to_hi     = 0;
  int unsigned vrise     = 0;
  int unsigned vrise_cyc = 0;
  int unsigned to_cyc    = 0;
  logic        v_prev    = 1'b0;

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    v_prev <= rx_valid;
    if (overrun === 1'b1) ovr_hi <= ovr_hi + 1;
    if (timeout === 1'b1) begin
      to_hi  <= to_hi + 1;
      to_cyc <= cyc;
    end
    if (rx_valid === 1'b1 && v_prev !== 1'b1) begin
      vrise     <= vrise + 1;
      vrise_cyc <= cyc;
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int unsigned cpb);
    rx = b;
    step(cpb);
  endtask

  task automatic send_frame(input logic [8:0] data, input int unsigned nb, input logic par_en,
                            input logic pbit, input logic s1, input logic s2, input logic two,
                            input int unsigned cpb);
    send_bit(1'b0, cpb);
    for (int i = 0; i < int'(nb); i++) send_bit(data[i], cpb);
    if (par_en) send_bit(pbit, cpb);
    send_bit(s1, cpb);
    if (two) send_bit(s2, cpb);
    rx = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int unsigned n = 0;
    while (rx_valid !== 1'b1 && n < 2000) begin
      step(1);
      n++;
    end
    check(tag, 32'(rx_valid), 32'd1);
  endtask

  task automatic accept(input string tag);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    check(tag, 32'(rx_valid), 32'd0);
  endtask

  function automatic logic par_of(input logic [8:0] d, input logic [1:0] mode);
    case (mode)
      2'b00:   return ($countones(d) % 2) == 1;
      2'b01:   return ($countones(d) % 2) == 0;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected {brk, fe, pe, data[8:0]} for one frame as seen on the line.
  function automatic logic [11:0] model(input logic [8:0] data, input int unsigned nb,
                                        input logic [2:0] par, input logic pbit,
                                        input logic s1, input logic s2, input logic two);
    logic [8:0] d;
    logic       pe, fe, brk;
    d = '0;
    for (int i = 0; i < int'(nb); i++) d[i] = data[i];
    pe  = par[0] && (pbit != par_of(d, par[2:1]));
    fe  = !s1 || (two && !s2);
    brk = (d == 9'd0) && !(par[0] && pbit) && !s1 && !(two && s2);
    return {brk, fe, pe, d};
  endfunction

  logic [8:0]  rdata;
  logic [11:0] exp_frame;
  logic        rpbit, rs1, rs2, rtwo;
  logic [2:0]  rpar;
  int unsigned rbits, rnb, rdiv, rcpb;
  int unsigned snap0, snap1;

  initial begin
    rst_n      = 1'b0;
    rx         = 1'b1;
    cfg_en     = 1'b1;
    cfg_div    = '0;
    cfg_bits   = 3'd3;
    cfg_parity = 3'b000;
    cfg_stop   = 1'b0;
    cfg_to     = '0;
    rx_ready   = 1'b0;
    step(4);

    check("rst valid", 32'(rx_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst data", 32'(rx_data), 32'd0);
    check("rst pulses", 32'({overrun, timeout, rx_pe, rx_fe, rx_brk}), 32'd0);
    rst_n = 1'b1;
    step(20);

    // 8N1 0xA5 held until accepted
    send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16);
    wait_valid("a5 valid");
    check("a5 data", 32'(rx_data), 32'h0A5);
    check("a5 flags", 32'({rx_brk, rx_fe, rx_pe}), 32'd0);
    step(40);
    check("a5 hold", 32'({rx_valid, rx_data}), 32'h2A5);
    accept("a5 clear");
    step(16);

    // 8E1 with wrong parity bit
    cfg_parity = 3'b001;
    send_frame(9'h003, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16);
    wait_valid("pe valid");
    check("pe data", 32'(rx_data), 32'h003);
    check("pe flags", 32'({rx_brk, rx_fe, rx_pe}), 32'd1);
    accept("pe clear");
    cfg_parity = 3'b000;
    step(16);

    // short low glitch is a false start
    snap0 = vrise;
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    step(10);
    check("glitch busy", 32'(busy), 32'd0);
    step(40);
    check("glitch no word", vrise - snap0, 32'd0);

    // back-to-back frames without reading
    snap0 = ovr_hi;
    send_frame(9'h011, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16);
    send_frame(9'h022, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16);
    step(2);
    check("ovr data", 32'(rx_data), 32'h011);
    check("ovr valid", 32'(rx_valid), 32'd1);
    check("ovr pulse cycles", ovr_hi - snap0, 32'd1);
    accept("ovr clear");
    step(16);

    // break: line low 12 bit times
    snap0 = vrise;
    rx = 1'b0;
    step(12 * 16);
    rx = 1'b1;
    step(48);
    check("brk words", vrise - snap0, 32'd1);
    check("brk data", 32'(rx_data), 32'h000);
    check("brk flags", 32'({rx_brk, rx_fe, rx_pe}), 32'd6);
    accept("brk clear");
    step(64);
    check("brk no restart", vrise - snap0, 32'd1);

    // idle timeout of 4 bit times
    cfg_to = 8'd4;
    snap0  = to_hi;
    send_frame(9'h05A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16);
    wait_valid("to valid");
    step(100);
    check("to pulses", to_hi - snap0, 32'd1);
    check("to delay", to_cyc - vrise_cyc, 32'd64);
    step(200);
    check("to once", to_hi - snap0, 32'd1);
    accept("to clear");
    cfg_to = '0;
    step(16);

    // randomized frames against the reference model
    for (int k = 0; k < 30; k++) begin
      rbits = $urandom_range(0, 7);
      rnb   = (5 + rbits > 9) ? 9 : 5 + rbits;
      rpar  = 3'($urandom_range(0, 7));
      rtwo  = 1'($urandom_range(0, 1));
      rdiv  = $urandom_range(0, 2);
      rcpb  = OVS * (rdiv + 1);
      rdata = 9'($urandom);
      rs1   = ($urandom_range(0, 4) != 0);
      rs2   = ($urandom_range(0, 4) != 0);
      rpbit = par_of(rdata & 9'((1 << rnb) - 1), rpar[2:1]) ^ ($urandom_range(0, 3) == 0);
      if (k % 8 == 3) begin
        rdata = '0;
        rpbit = 1'b0;
        rs1   = 1'b0;
        rs2   = 1'b0;
      end
      cfg_bits   = 3'(rbits);
      cfg_parity = rpar;
      cfg_stop   = rtwo;
      cfg_div    = DIV_W'(rdiv);
      exp_frame  = model(rdata, rnb, rpar, rpbit, rs1, rs2, rtwo);
      step(2);
      send_frame(rdata, rnb, rpar[0], rpbit, rs1, rs2, rtwo, rcpb);
      wait_valid("rnd valid");
      check("rnd frame", 32'({rx_brk, rx_fe, rx_pe, rx_data}), 32'(exp_frame));
      accept("rnd clear");
      step(2 * rcpb);
    end
    cfg_div    = '0;
    cfg_bits   = 3'd3;
    cfg_parity = 3'b000;
    cfg_stop   = 1'b0;
    step(16);

    // reset in the middle of a frame with a word pending
    send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16);
    wait_valid("mid valid");
    snap1 = vrise;
    rx = 1'b0;
    step(40);
    check("mid busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step(1);
    check("mid rst outs",
          32'({rx_data, rx_pe, rx_fe, rx_brk, rx_valid, overrun, timeout, busy}), 32'd0);
    rx = 1'b1;
    step(3);
    rst_n = 1'b1;
    step(20);
    check("mid after rst", 32'({rx_valid, busy}), 32'd0);
    check("mid no word", vrise - snap1, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
